// File: rtl/rsv_pc_gen_if.sv
// PC-generation port bundle: redirect/stall controls into the PC stage and fetch PC, flush and misalign outputs.
// master drives the controls (execute/hazard side); slave is the PC generator itself.
interface rsv_pc_gen_if;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        trap_req_i;
    logic [31:0] trap_vec_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic [31:0] pc_plus4_o;
    logic        flush_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    modport master (
        output stall_i, branch_taken_i, branch_target_i, trap_req_i, trap_vec_i,
        input  pc_o, pc_valid_o, pc_plus4_o, flush_o, misalign_o, misalign_addr_o
    );

    modport slave (
        input  stall_i, branch_taken_i, branch_target_i, trap_req_i, trap_vec_i,
        output pc_o, pc_valid_o, pc_plus4_o, flush_o, misalign_o, misalign_addr_o
    );
endinterface

// File: rtl/rsv_pc_gen.sv
// Fetch PC generator: sequential +4 advance, stall hold, branch/trap redirect with one-cycle flush.
// Redirects visible one edge after sampling; stall holds the PC but never delays a redirect.
module rsv_pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    rsv_pc_gen_if.slave  pc_if
);

    typedef enum logic [1:0] {BOOT, RUN, EXC} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] maddr_q, maddr_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        mis_q, mis_d;
    logic [31:0] trap_pc;

    // Trap vectors are forced word-aligned rather than faulted.
    assign trap_pc = pc_if.trap_vec_i & ~32'h3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            maddr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
            maddr_q <= maddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        flush_d = 1'b0;
        mis_d   = 1'b0;
        maddr_d = maddr_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN: begin
                if (pc_if.trap_req_i) begin
                    pc_d    = trap_pc;
                    flush_d = 1'b1;
                end else if (pc_if.branch_taken_i) begin
                    flush_d = 1'b1;
                    if (pc_if.branch_target_i[1:0] == 2'b00) begin
                        pc_d = pc_if.branch_target_i;
                    end else begin
                        // Misaligned target: PC freezes and fetch is parked until a trap arrives.
                        mis_d   = 1'b1;
                        maddr_d = pc_if.branch_target_i;
                        state_d = EXC;
                        valid_d = 1'b0;
                    end
                end else if (!pc_if.stall_i) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            EXC: begin
                if (pc_if.trap_req_i) begin
                    pc_d    = trap_pc;
                    flush_d = 1'b1;
                    valid_d = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    assign pc_if.pc_o            = pc_q;
    assign pc_if.pc_valid_o      = valid_q;
    assign pc_if.pc_plus4_o      = pc_q + 32'd4;
    assign pc_if.flush_o         = flush_q;
    assign pc_if.misalign_o      = mis_q;
    assign pc_if.misalign_addr_o = maddr_q;

endmodule

// File: tb/tb_rsv_pc_gen.sv
// Scoreboard bench for rsv_pc_gen: directed vectors push expected post-edge outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_rsv_pc_gen;

    logic clk;
    logic reset;

    rsv_pc_gen_if pc_if ();

    rsv_pc_gen #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .pc_if (pc_if)
    );

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] plus4;
        logic        flush;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs are driven now (just after a falling edge); expectation applies after the next rising edge.
    task automatic step(input logic stall, input logic br, input logic [31:0] tgt,
                        input logic trap, input logic [31:0] vec,
                        input logic [31:0] epc, input logic [31:31] evalid,
                        input logic [31:0] eplus4, input logic eflush,
                        input logic emis, input logic [31:0] emaddr);
        exp_t e;
        pc_if.stall_i         = stall;
        pc_if.branch_taken_i  = br;
        pc_if.branch_target_i = tgt;
        pc_if.trap_req_i      = trap;
        pc_if.trap_vec_i      = vec;
        e.pc    = epc;
        e.valid = evalid;
        e.plus4 = eplus4;
        e.flush = eflush;
        e.mis   = emis;
        e.maddr = emaddr;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    pc_if.pc_o, 32'h0);
        chk({tag, "_valid"}, {31'h0, pc_if.pc_valid_o}, 32'h0);
        chk({tag, "_flush"}, {31'h0, pc_if.flush_o}, 32'h0);
        chk({tag, "_mis"},   {31'h0, pc_if.misalign_o}, 32'h0);
        chk({tag, "_maddr"}, pc_if.misalign_addr_o, 32'h0);
    endtask

    // Monitor: compare every queued expectation one time unit after a rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc",    pc_if.pc_o, e.pc);
                chk("valid", {31'h0, pc_if.pc_valid_o}, {31'h0, e.valid});
                chk("plus4", pc_if.pc_plus4_o, e.plus4);
                chk("flush", {31'h0, pc_if.flush_o}, {31'h0, e.flush});
                chk("mis",   {31'h0, pc_if.misalign_o}, {31'h0, e.mis});
                if (e.mis)
                    chk("maddr", pc_if.misalign_addr_o, e.maddr);
            end
        end
    end

    initial begin
        reset = 1'b1;
        pc_if.stall_i         = 1'b0;
        pc_if.branch_taken_i  = 1'b0;
        pc_if.branch_target_i = 32'h0;
        pc_if.trap_req_i      = 1'b0;
        pc_if.trap_vec_i      = 32'h0;

        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        #1;
        chk_reset_vals("boot");

        //    stall br  target        trap vec           pc            v  plus4         fl mis maddr
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 32'h0000_0004, 0, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 32'h0000_0008, 0, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 1, 32'h0000_000C, 0, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_000C, 1, 32'h0000_0010, 0, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 32'h0000_0014, 0, 0, 32'h0);
        step(1, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 32'h0000_0014, 0, 0, 32'h0);
        step(1, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 32'h0000_0014, 0, 0, 32'h0);
        step(1, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 32'h0000_0014, 0, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0014, 1, 32'h0000_0018, 0, 0, 32'h0);
        step(1, 1, 32'h100,      0, 32'h0,        32'h0000_0100, 1, 32'h0000_0104, 1, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 1, 32'h0000_0108, 0, 0, 32'h0);
        step(0, 1, 32'h100,      1, 32'h203,      32'h0000_0200, 1, 32'h0000_0204, 1, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0204, 1, 32'h0000_0208, 0, 0, 32'h0);
        step(0, 1, 32'h102,      0, 32'h0,        32'h0000_0204, 0, 32'h0000_0208, 1, 1, 32'h102);
        step(0, 1, 32'h300,      0, 32'h0,        32'h0000_0204, 0, 32'h0000_0208, 0, 0, 32'h0);
        step(1, 0, 32'h0,        0, 32'h0,        32'h0000_0204, 0, 32'h0000_0208, 0, 0, 32'h0);
        step(0, 0, 32'h0,        1, 32'h80,       32'h0000_0080, 1, 32'h0000_0084, 1, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0084, 1, 32'h0000_0088, 0, 0, 32'h0);
        step(0, 1, 32'hFFFF_FFF8,0, 32'h0,        32'hFFFF_FFF8, 1, 32'hFFFF_FFFC, 1, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 1, 32'h0000_0000, 0, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 32'h0000_0004, 0, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 32'h0000_0008, 0, 0, 32'h0);
        step(0, 1, 32'h40A,      0, 32'h0,        32'h0000_0004, 0, 32'h0000_0008, 1, 1, 32'h40A);

        // Mid-run reset while parked in EXC with a trap pending: must clear without a clock edge.
        pc_if.trap_req_i = 1'b1;
        pc_if.trap_vec_i = 32'h500;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        chk_reset_vals("midrst_hold");
        reset = 1'b0;
        #1;
        chk_reset_vals("reboot");

        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 32'h0000_0004, 0, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 32'h0000_0008, 0, 0, 32'h0);
        step(1, 0, 32'h0,        1, 32'h13,       32'h0000_0010, 1, 32'h0000_0014, 1, 0, 32'h0);
        step(0, 0, 32'h0,        0, 32'h0,        32'h0000_0014, 1, 32'h0000_0018, 0, 0, 32'h0);

        pc_if.stall_i = 1'b1;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
